// File: rtl/light_level_ctrl.sv
// ---------------------------------------------------------------------------
// light_level_ctrl
//
// Decides how many lamps are lit and drives the 4-bit lamp count consumed by
// the downstream lamp-state decoder. Occupancy, an ambient brightness reading
// and a manual override are combined into a target count. In the automatic
// states (IDLE/ACTIVE/GRACE) the registered count ramps toward the target one
// lamp per STEP_CYCLES clocks. When the room empties, the lamps keep tracking
// the occupied target for HOLD_CYCLES clocks (GRACE) before IDLE brings the
// target to zero. MANUAL loads manual_level directly with no ramp.
//
// Parameters:
//   STEP_CYCLES   clocks per single-lamp ramp step (>= 1)
//   HOLD_CYCLES   grace period in clocks after occupancy drops (>= 1)
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   occupied       presence sensor, 1 = occupied
//   ambient        ambient brightness, 0 = dark .. 15 = full daylight
//   manual_mode    1 = manual override active
//   manual_level   requested lamp count while in manual mode
//   active_lights  registered lamp count for the lamp-state decoder
//   at_target      combinational, 1 when active_lights == target
//   state          current FSM state (IDLE=0, ACTIVE=1, GRACE=2, MANUAL=3)
// ---------------------------------------------------------------------------
module light_level_ctrl #(
    parameter int STEP_CYCLES = 1000,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       occupied,
    input  logic [3:0] ambient,
    input  logic       manual_mode,
    input  logic [3:0] manual_level,
    output logic [3:0] active_lights,
    output logic       at_target,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GRACE  = 2'd2,
        MANUAL = 2'd3
    } state_t;

    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int GW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
    localparam logic [GW-1:0] GRACE_LAST = GW'(HOLD_CYCLES - 1);

    state_t         state_q;
    state_t         state_d;
    logic [SW-1:0]  step_cnt;
    logic [GW-1:0]  grace_cnt;
    logic [3:0]     target;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic; manual_mode wins over everything else
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (manual_mode) begin
            state_d = MANUAL;
        end else begin
            case (state_q)
                IDLE:    if (occupied) state_d = ACTIVE;
                ACTIVE:  if (!occupied) state_d = GRACE;
                GRACE: begin
                    if (occupied) begin
                        state_d = ACTIVE;
                    end else if (grace_cnt == GRACE_LAST) begin
                        state_d = IDLE;
                    end
                end
                MANUAL:  state_d = occupied ? ACTIVE : GRACE;
                default: state_d = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (target is a function of the current state)
    // -----------------------------------------------------------------------
    always_comb begin
        target = 4'd0;
        case (state_q)
            IDLE:           target = 4'd0;
            ACTIVE, GRACE:  target = 4'd15 - ambient;
            MANUAL:         target = manual_level;
            default:        target = 4'd0;
        endcase
        at_target = (active_lights == target);
        state     = state_q;
    end

    // -----------------------------------------------------------------------
    // Grace counter: counts only while staying in GRACE. Entering GRACE
    // (from ACTIVE or MANUAL) and every other state see it at zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            grace_cnt <= '0;
        end else if (state_q == GRACE && state_d == GRACE) begin
            grace_cnt <= grace_cnt + 1'b1;
        end else begin
            grace_cnt <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Lamp count and ramp step counter.
    // The manual load also covers the edge that enters MANUAL and the edge
    // that leaves it, so ramping after release starts from manual_level.
    // The step counter is not cleared on a target change; the direction is
    // re-evaluated at each step, so the count never overshoots or wraps.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            active_lights <= 4'd0;
            step_cnt      <= '0;
        end else if (manual_mode || state_q == MANUAL) begin
            active_lights <= manual_level;
            step_cnt      <= '0;
        end else if (active_lights != target) begin
            if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                if (active_lights < target) begin
                    active_lights <= active_lights + 4'd1;
                end else begin
                    active_lights <= active_lights - 4'd1;
                end
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end else begin
            step_cnt <= '0;
        end
    end

endmodule
